// File: rtl/enigma_pkg.sv
// Shared definitions for the three-rotor Enigma step controller.
//   - letter constants A..Z and the alphabet size
//   - controller state encoding
//   - default notch positions and rotor wiring configs
//   - lookup-mode encodings ({reflect, inverse})
//   - position increment helper with 25 -> 0 wrap
package enigma_pkg;

  localparam int LETTERS = 26;

  localparam logic [4:0] LTR_A = 5'd0;
  localparam logic [4:0] LTR_B = 5'd1;
  localparam logic [4:0] LTR_C = 5'd2;
  localparam logic [4:0] LTR_D = 5'd3;
  localparam logic [4:0] LTR_E = 5'd4;
  localparam logic [4:0] LTR_F = 5'd5;
  localparam logic [4:0] LTR_G = 5'd6;
  localparam logic [4:0] LTR_H = 5'd7;
  localparam logic [4:0] LTR_I = 5'd8;
  localparam logic [4:0] LTR_J = 5'd9;
  localparam logic [4:0] LTR_K = 5'd10;
  localparam logic [4:0] LTR_L = 5'd11;
  localparam logic [4:0] LTR_M = 5'd12;
  localparam logic [4:0] LTR_N = 5'd13;
  localparam logic [4:0] LTR_O = 5'd14;
  localparam logic [4:0] LTR_P = 5'd15;
  localparam logic [4:0] LTR_Q = 5'd16;
  localparam logic [4:0] LTR_R = 5'd17;
  localparam logic [4:0] LTR_S = 5'd18;
  localparam logic [4:0] LTR_T = 5'd19;
  localparam logic [4:0] LTR_U = 5'd20;
  localparam logic [4:0] LTR_V = 5'd21;
  localparam logic [4:0] LTR_W = 5'd22;
  localparam logic [4:0] LTR_X = 5'd23;
  localparam logic [4:0] LTR_Y = 5'd24;
  localparam logic [4:0] LTR_Z = 5'd25;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STEP,
    ST_FWD_R,
    ST_FWD_M,
    ST_FWD_L,
    ST_REFL,
    ST_INV_L,
    ST_INV_M,
    ST_INV_R,
    ST_DONE
  } state_t;

  localparam int NOTCH_R_DEFAULT = 21;  // V
  localparam int NOTCH_M_DEFAULT = 4;   // E

  localparam logic [1:0] CFG_ROTOR_I   = 2'd0;
  localparam logic [1:0] CFG_ROTOR_II  = 2'd1;
  localparam logic [1:0] CFG_ROTOR_III = 2'd2;

  // {reflect, inverse}
  localparam logic [1:0] LUT_MODE_FWD  = 2'b00;
  localparam logic [1:0] LUT_MODE_INV  = 2'b01;
  localparam logic [1:0] LUT_MODE_REFL = 2'b10;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p >= LTR_Z) ? LTR_A : p + 5'd1;
  endfunction

endpackage

// File: rtl/mod26_offset.sv
// Modulo-26 offset unit: y = (a + b) mod 26 when sub=0, (a - b) mod 26 when sub=1.
// Ports:
//   a   in  5  letter (0..25)
//   b   in  5  rotor offset (0..25)
//   sub in  1  select subtraction
//   y   out 5  result (0..25)
module mod26_offset
  import enigma_pkg::*;
(
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       sub,
  output logic [4:0] y
);

  logic [5:0] raw;

  // Subtraction is biased by +26 so one conditional subtract covers both cases.
  always_comb begin
    if (sub) raw = {1'b0, a} + 6'(LETTERS) - {1'b0, b};
    else     raw = {1'b0, a} + {1'b0, b};
    if (raw >= 6'(LETTERS)) y = 5'(raw - 6'(LETTERS));
    else                    y = raw[4:0];
  end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Three-rotor Enigma sequencing controller. Accepts a plaintext letter,
// ratchet-steps the rotors (with double step), then walks the shared wiring
// lookup through seven passes and presents the ciphertext.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   key_valid/key_ready/key_letter  plaintext handshake
//   load_en, load_l/m/r             rotor start positions (IDLE only)
//   pos_l/m/r                       current rotor positions
//   lut_cfg/reflect/inverse/in      drive to the shared wiring lookup
//   lut_out                         lookup result, same cycle
//   out_valid/out_ready/out_letter  ciphertext handshake
//   busy                            not IDLE
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for a key or a position load
// STEP     | ratchet rotors using pre-step positions
// FWD_R    | right rotor, forward
// FWD_M    | middle rotor, forward
// FWD_L    | left rotor, forward
// REFL     | reflector B
// INV_L    | left rotor, inverse
// INV_M    | middle rotor, inverse
// INV_R    | right rotor, inverse
// DONE     | ciphertext held until out_ready
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int         NOTCH_R = NOTCH_R_DEFAULT,
  parameter int         NOTCH_M = NOTCH_M_DEFAULT,
  parameter logic [1:0] CFG_L   = CFG_ROTOR_I,
  parameter logic [1:0] CFG_M   = CFG_ROTOR_II,
  parameter logic [1:0] CFG_R   = CFG_ROTOR_III
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [4:0] key_letter,
  input  logic       load_en,
  input  logic [4:0] load_l,
  input  logic [4:0] load_m,
  input  logic [4:0] load_r,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic [1:0] lut_cfg,
  output logic       lut_reflect,
  output logic       lut_inverse,
  output logic [4:0] lut_in,
  input  logic [4:0] lut_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_letter,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [4:0] w_q;
  logic [4:0] pos_l_q, pos_m_q, pos_r_q;

  logic       lookup_active;
  logic [1:0] lut_mode;
  logic [1:0] stage_cfg;
  logic [4:0] stage_off;
  logic [4:0] add_y;
  logic [4:0] w_stage;
  logic       key_take;

  assign key_take = (state_q == ST_IDLE) && !load_en && key_valid;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    lookup_active = 1'b0;
    lut_mode      = LUT_MODE_FWD;
    stage_cfg     = 2'd0;
    stage_off     = 5'd0;
    unique case (state_q)
      ST_IDLE: if (key_take && key_letter <= LTR_Z) state_d = ST_STEP;
      ST_STEP: state_d = ST_FWD_R;
      ST_FWD_R: begin
        lookup_active = 1'b1;
        stage_cfg     = CFG_R;
        stage_off     = pos_r_q;
        state_d       = ST_FWD_M;
      end
      ST_FWD_M: begin
        lookup_active = 1'b1;
        stage_cfg     = CFG_M;
        stage_off     = pos_m_q;
        state_d       = ST_FWD_L;
      end
      ST_FWD_L: begin
        lookup_active = 1'b1;
        stage_cfg     = CFG_L;
        stage_off     = pos_l_q;
        state_d       = ST_REFL;
      end
      // Zero offset makes the shared offset path pass w and lut_out through.
      ST_REFL: begin
        lookup_active = 1'b1;
        lut_mode      = LUT_MODE_REFL;
        state_d       = ST_INV_L;
      end
      ST_INV_L: begin
        lookup_active = 1'b1;
        lut_mode      = LUT_MODE_INV;
        stage_cfg     = CFG_L;
        stage_off     = pos_l_q;
        state_d       = ST_INV_M;
      end
      ST_INV_M: begin
        lookup_active = 1'b1;
        lut_mode      = LUT_MODE_INV;
        stage_cfg     = CFG_M;
        stage_off     = pos_m_q;
        state_d       = ST_INV_R;
      end
      ST_INV_R: begin
        lookup_active = 1'b1;
        lut_mode      = LUT_MODE_INV;
        stage_cfg     = CFG_R;
        stage_off     = pos_r_q;
        state_d       = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry side: letter shifted into the rotor's frame.
  mod26_offset u_off_in (
    .a   (w_q),
    .b   (stage_off),
    .sub (1'b0),
    .y   (add_y)
  );

  // Exit side: lookup result shifted back out of the rotor's frame.
  mod26_offset u_off_out (
    .a   (lut_out),
    .b   (stage_off),
    .sub (1'b1),
    .y   (w_stage)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      w_q     <= 5'd0;
      pos_l_q <= 5'd0;
      pos_m_q <= 5'd0;
      pos_r_q <= 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            pos_l_q <= (load_l > LTR_Z) ? 5'd0 : load_l;
            pos_m_q <= (load_m > LTR_Z) ? 5'd0 : load_m;
            pos_r_q <= (load_r > LTR_Z) ? 5'd0 : load_r;
          end else if (key_take && key_letter <= LTR_Z) begin
            w_q <= key_letter;
          end
        end
        ST_STEP: begin
          pos_r_q <= inc26(pos_r_q);
          if (pos_r_q == 5'(NOTCH_R) || pos_m_q == 5'(NOTCH_M))
            pos_m_q <= inc26(pos_m_q);
          // Middle rotor at its notch also carries the left rotor (double step).
          if (pos_m_q == 5'(NOTCH_M))
            pos_l_q <= inc26(pos_l_q);
        end
        default: if (lookup_active) w_q <= w_stage;
      endcase
    end
  end

  assign key_ready   = (state_q == ST_IDLE) && !load_en;
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_letter  = w_q;
  assign pos_l       = pos_l_q;
  assign pos_m       = pos_m_q;
  assign pos_r       = pos_r_q;
  assign lut_cfg     = stage_cfg;
  assign lut_reflect = lut_mode[1];
  assign lut_inverse = lut_mode[0];
  assign lut_in      = lookup_active ? add_y : 5'd0;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
module tb_enigma_step_ctrl;
  import enigma_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic       key_ready;
  logic [4:0] key_letter;
  logic       load_en;
  logic [4:0] load_l, load_m, load_r;
  logic [4:0] pos_l, pos_m, pos_r;
  logic [1:0] lut_cfg;
  logic       lut_reflect;
  logic       lut_inverse;
  logic [4:0] lut_in;
  logic [4:0] lut_out;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_letter;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  enigma_step_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_letter  (key_letter),
    .load_en     (load_en),
    .load_l      (load_l),
    .load_m      (load_m),
    .load_r      (load_r),
    .pos_l       (pos_l),
    .pos_m       (pos_m),
    .pos_r       (pos_r),
    .lut_cfg     (lut_cfg),
    .lut_reflect (lut_reflect),
    .lut_inverse (lut_inverse),
    .lut_in      (lut_in),
    .lut_out     (lut_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_letter  (out_letter),
    .busy        (busy)
  );

  // Historical wirings: rotors I, II, III and reflector B.
  function automatic logic [4:0] wire_map(input logic [1:0] cfg, input logic refl,
                                          input logic inv, input logic [4:0] x);
    string s;
    int    idx;
    if (refl) s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    else if (cfg == 2'd1) s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    else if (cfg == 2'd2) s = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    else s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    idx = int'(x);
    if (idx > 25) return 5'd0;
    if (!inv) return 5'(int'(s[idx]) - 65);
    for (int j = 0; j < 26; j++)
      if (int'(s[j]) - 65 == idx) return 5'(j);
    return 5'd0;
  endfunction

  assign lut_out = wire_map(lut_cfg, lut_reflect, lut_inverse, lut_in);

  function automatic int md(input int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int pass(input int cfg, input int refl, input int inv,
                              input int x, input int p);
    return md(int'(wire_map(2'(cfg), 1'(refl), 1'(inv), 5'(md(x + p)))) - p);
  endfunction

  // Cipher of letter c with post-step positions l, m, r.
  function automatic logic [4:0] enc(input int c, input int l, input int m, input int r);
    int x;
    x = c;
    x = pass(2, 0, 0, x, r);
    x = pass(1, 0, 0, x, m);
    x = pass(0, 0, 0, x, l);
    x = pass(0, 1, 0, x, 0);
    x = pass(0, 0, 1, x, l);
    x = pass(1, 0, 1, x, m);
    x = pass(2, 0, 1, x, r);
    return 5'(x);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic press(input logic [4:0] k);
    key_letter = k;
    key_valid  = 1'b1;
    tick();
    key_valid  = 1'b0;
  endtask

  task automatic encrypt_one(input string tag, input logic [4:0] k, input logic [4:0] exp_c,
                             input logic [4:0] el, input logic [4:0] em, input logic [4:0] er);
    press(k);
    wait_valid(tag);
    check({tag, "_letter"}, 32'(out_letter), 32'(exp_c));
    check({tag, "_pos"}, 32'({pos_l, pos_m, pos_r}), 32'({el, em, er}));
    tick();
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    load_en = 1'b1;
    load_l  = l;
    load_m  = m;
    load_r  = r;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    logic [4:0] aaaaa [5];
    logic [4:0] held;
    logic       seen;

    reset = 1'b1;
    key_valid = 1'b0;
    key_letter = 5'd0;
    load_en = 1'b0;
    load_l = 5'd0;
    load_m = 5'd0;
    load_r = 5'd0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_pos", 32'({pos_l, pos_m, pos_r}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_letter", 32'(out_letter), 32'd0);
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lut", 32'({lut_cfg, lut_reflect, lut_inverse, lut_in}), 32'd0);

    // AAAAA from AAA -> BDZGO
    aaaaa[0] = LTR_B;
    aaaaa[1] = LTR_D;
    aaaaa[2] = LTR_Z;
    aaaaa[3] = LTR_G;
    aaaaa[4] = LTR_O;
    for (int i = 0; i < 5; i++)
      encrypt_one($sformatf("aaa%0d", i), LTR_A, aaaaa[i], 5'd0, 5'd0, 5'(i + 1));

    // Double step: ADU -> ADV -> AEW -> BFX
    load_en = 1'b1;
    load_l = 5'd0;
    load_m = 5'd3;
    load_r = 5'd20;
    #1;
    check("load_key_ready", 32'(key_ready), 32'd0);
    tick();
    load_en = 1'b0;
    check("load_adu", 32'({pos_l, pos_m, pos_r}), 32'({5'd0, 5'd3, 5'd20}));
    encrypt_one("dbl0", LTR_H, enc(7, 0, 3, 21), 5'd0, 5'd3, 5'd21);
    encrypt_one("dbl1", LTR_H, enc(7, 0, 4, 22), 5'd0, 5'd4, 5'd22);
    encrypt_one("dbl2", LTR_H, enc(7, 1, 5, 23), 5'd1, 5'd5, 5'd23);

    // Right rotor wrap, no middle carry with NOTCH_R=21
    load(5'd0, 5'd0, 5'd25);
    encrypt_one("wrap", LTR_Q, enc(16, 0, 0, 0), 5'd0, 5'd0, 5'd0);

    // Back-pressure: hold out_ready low, poke key and load inputs
    out_ready = 1'b0;
    press(LTR_M);
    wait_valid("hold");
    held = enc(12, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      key_valid  = i[0];
      key_letter = 5'd2;
      load_en    = ~i[0];
      load_l     = 5'd9;
      tick();
      check($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("hold_letter%0d", i), 32'(out_letter), 32'(held));
      check($sformatf("hold_ready%0d", i), 32'(key_ready), 32'd0);
    end
    key_valid = 1'b0;
    load_en   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    check("release_pos", 32'({pos_l, pos_m, pos_r}), 32'({5'd0, 5'd0, 5'd1}));

    // Reset while in INV_M
    load(5'd3, 5'd4, 5'd5);
    press(LTR_K);
    for (int i = 0; i < 6; i++) tick();
    check("invm_mode", 32'({lut_cfg, lut_reflect, lut_inverse}), 32'({2'd1, 1'b0, 1'b1}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pos", 32'({pos_l, pos_m, pos_r}), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);

    // Out-of-range key: accepted and dropped
    load(5'd1, 5'd2, 5'd3);
    key_letter = 5'd27;
    key_valid  = 1'b1;
    #1;
    check("bad_key_ready", 32'(key_ready), 32'd1);
    tick();
    key_valid = 1'b0;
    check("bad_key_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    check("bad_key_quiet", 32'(seen), 32'd0);
    check("bad_key_pos", 32'({pos_l, pos_m, pos_r}), 32'({5'd1, 5'd2, 5'd3}));

    // Out-of-range load values clamp to 0
    load(5'd7, 5'd30, 5'd26);
    check("load_clamp", 32'({pos_l, pos_m, pos_r}), 32'({5'd7, 5'd0, 5'd0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
